// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   Instruction-fetch sequencer for the RV32I 5-stage pipeline. Owns the PC,
//   keeps at most one request outstanding to instruction memory and loads the
//   IF/ID register feeding decode. Honours stall from the hazard unit and
//   redirects from EX, discarding the response of any wrong-path fetch.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   imem_req / imem_addr   fetch request (level, held until imem_rvalid), address
//   imem_rvalid/imem_rdata response; completes the transfer while imem_req=1
//   stall_i                hold IF/ID and PC
//   redirect_i/_pc_i       taken control transfer from EX and its target
//   ifid_valid/_pc/_instr  IF/ID register contents (NOP_INSTR when not valid)
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;         // next sequential fetch address (or redirect target)
    logic [31:0] skid_pc, skid_instr;
    logic        skid_ld;
    logic        ld_ifid, bubble;
    logic [31:0] ld_pc, ld_instr;
    logic        done;
    logic [31:0] target;

    assign done   = imem_req & imem_rvalid;
    assign target = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        skid_ld  = 1'b0;
        ld_ifid  = 1'b0;
        bubble   = 1'b0;
        ld_pc    = pc;
        ld_instr = imem_rdata;
        case (state)
            FETCH: begin
                if (redirect_i) begin
                    pc_n   = target;
                    bubble = 1'b1;
                    // An incomplete request cannot be withdrawn; wait it out.
                    state_n = done ? FETCH : SQUASH;
                end else if (done) begin
                    pc_n = pc + 32'd4;
                    if (stall_i) begin
                        skid_ld = 1'b1;
                        state_n = HOLD;
                    end else begin
                        ld_ifid = 1'b1;
                    end
                end else if (!stall_i) begin
                    bubble = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_n    = target;
                    bubble  = 1'b1;
                    state_n = FETCH;
                end else if (!stall_i) begin
                    ld_ifid  = 1'b1;
                    ld_pc    = skid_pc;
                    ld_instr = skid_instr;
                    state_n  = FETCH;
                end
            end
            SQUASH: begin
                bubble = 1'b1;
                if (redirect_i) pc_n = target;
                if (done) state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            skid_pc    <= '0;
            skid_instr <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            imem_req <= (state_n != HOLD);
            // While squashing, the wrong-path address stays on the bus.
            if (state_n != SQUASH) imem_addr <= pc_n;
            if (skid_ld) begin
                skid_pc    <= pc;
                skid_instr <= imem_rdata;
            end
            if (bubble) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (ld_ifid) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= ld_pc;
                ifid_instr <= ld_instr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl with a transaction-level reference model.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_instr;

    if_fetch_ctrl #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an outstanding request (possibly wrong-path), at most one
    // buffered instruction waiting out a stall, and the IF/ID contents.
    logic        m_req, m_wrong, m_held;
    logic [31:0] m_addr, m_next, m_hpc, m_hins;
    logic        m_v;
    logic [31:0] m_pc, m_ins;
    int          mem_wait;
    int          wmin, wmax, stall_pct, redir_pct, rst_pct;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a ^ 32'h5A5A_0000) * 32'h0001_0003 + 32'h0000_0777;
    endfunction

    task automatic model_reset();
        m_req = 0; m_wrong = 0; m_held = 0;
        m_addr = RST_PC; m_next = RST_PC; m_hpc = 0; m_hins = 0;
        m_v = 0; m_pc = 0; m_ins = NOP;
        mem_wait = $urandom_range(wmax, wmin);
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] tg,
                        input logic rv, input logic [31:0] data);
        logic done;
        done = m_req && rv;
        if (rd) begin
            m_v = 0; m_ins = NOP; m_held = 0;
            m_next = {tg[31:2], 2'b00};
            if (m_req && !done) m_wrong = 1;
            else begin m_wrong = 0; m_req = 1; m_addr = m_next; end
        end else if (m_wrong) begin
            m_v = 0; m_ins = NOP;
            if (done) begin m_wrong = 0; m_req = 1; m_addr = m_next; end
        end else if (m_held) begin
            if (!st) begin
                m_v = 1; m_pc = m_hpc; m_ins = m_hins;
                m_held = 0; m_req = 1; m_addr = m_next;
            end
        end else if (done) begin
            m_next = m_addr + 32'd4;
            if (st) begin m_held = 1; m_hpc = m_addr; m_hins = data; m_req = 0; end
            else begin m_v = 1; m_pc = m_addr; m_ins = data; m_addr = m_next; end
        end else begin
            if (!st) begin m_v = 0; m_ins = NOP; end
            m_req = 1; m_addr = m_next;
        end
        // memory: new random latency for each new request
        if (done) mem_wait = $urandom_range(wmax, wmin);
        else if (m_req && rv == 0 && mem_wait > 0 && !done) mem_wait = mem_wait;
    endtask

    task automatic check_outputs();
        chk("req", {31'b0, imem_req}, {31'b0, m_req});
        if (m_req) chk("addr", imem_addr, m_addr);
        chk("valid", {31'b0, ifid_valid}, {31'b0, m_v});
        chk("ifid_pc", ifid_pc, m_pc);
        chk("ifid_instr", ifid_instr, m_ins);
    endtask

    // Asynchronous reset: outputs must reach reset values without a clock edge.
    task automatic do_reset();
        #2 rst_n = 0;
        stall_i = 0; redirect_i = 0; imem_rvalid = 0;
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc", ifid_pc, 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        repeat (2) @(negedge clk);
        rst_n = 1;
        model_reset();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic run(input int cycles);
        logic st, rd, rv;
        logic [31:0] tg, data;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_outputs();
            if (rst_pct > 0 && m_wrong && ($urandom % 100) < rst_pct) begin
                do_reset();
                continue;
            end
            st = (($urandom % 100) < stall_pct);
            rd = (($urandom % 100) < redir_pct);
            case ($urandom % 4)
                0: tg = $urandom;
                1: tg = 32'hFFFF_FFF8 | ($urandom % 4);
                2: tg = 32'h0000_0103;
                default: tg = 32'hFFFF_FFFC;
            endcase
            if (m_req) begin
                rv = (mem_wait == 0);
                if (!rv) mem_wait--;
            end else begin
                rv = (($urandom % 4) == 0);   // stray response, must be ignored
            end
            data = (rv && m_req) ? memf(m_addr) : $urandom;
            stall_i = st; redirect_i = rd; redirect_pc_i = tg;
            imem_rvalid = rv; imem_rdata = data;
            step(st, rd, tg, rv, data);
        end
    endtask

    initial begin
        wmin = 0; wmax = 0; stall_pct = 0; redir_pct = 0; rst_pct = 0;
        @(negedge clk);
        do_reset();
        run(40);                                   // 0-wait, streaming
        wmin = 2; wmax = 2;  run(45);              // fixed 2-wait
        wmin = 0; wmax = 3; stall_pct = 30; run(300);
        wmin = 0; wmax = 4; redir_pct = 12; run(1500);
        rst_pct = 10; run(1500);                   // includes reset mid-squash
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
